// File: rtl/avalon_fp_master_pkg.sv
// Shared types and register map for the Avalon-MM floating-point adder master.
package avalon_fp_master_pkg;

  typedef enum logic [3:0] {
    IDLE, WR_A_LO, WR_A_HI, WR_B_LO, WR_B_HI, SETTLE, RD_REQ, RD_WAIT, RESP, SRST
  } state_e;

  localparam logic [2:0]  ADDR_A    = 3'd0;
  localparam logic [2:0]  ADDR_B    = 3'd1;
  localparam logic [2:0]  ADDR_CTRL = 3'd2;

  localparam logic [7:0]  BE_LO  = 8'h0F;
  localparam logic [7:0]  BE_HI  = 8'hF0;
  localparam logic [7:0]  BE_ALL = 8'hFF;

  localparam logic [63:0] SRST_CMD = 64'h1;

  // States that put a request on the Avalon bus and are subject to the stall timeout.
  function automatic logic is_xfer(state_e s);
    return s inside {WR_A_LO, WR_A_HI, WR_B_LO, WR_B_HI, RD_REQ, SRST};
  endfunction

endpackage

// File: rtl/avalon_fp_master_if.sv
// Command/response handshake plus Avalon-MM master bus of the FP adder master.
interface avalon_fp_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;
  logic        cmd_srst;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  avm_address;
  logic [63:0] avm_writedata;
  logic        avm_write;
  logic        avm_read;
  logic [7:0]  avm_byteenable;
  logic [63:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_srst, rsp_ready, avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, avm_address, avm_writedata,
           avm_write, avm_read, avm_byteenable, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_srst, rsp_ready, avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, avm_address, avm_writedata,
           avm_write, avm_read, avm_byteenable, busy
  );
endinterface

// File: rtl/avalon_fp_master_stall_timer.sv
// Counts cycles a pending Avalon request is held off by waitrequest; flags expiry.
module avm_stall_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic stall_i,
  output logic expired_o
);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (stall_i) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q >= 32'(TIMEOUT_CYCLES));

endmodule

// File: rtl/avalon_fp_master.sv
// Drives an Avalon-MM FP adder slave: four 32-bit-lane operand writes, settle, one read.
module avalon_fp_master
  import avalon_fp_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned READ_LATENCY   = 1
) (
  input logic                clk,
  input logic                reset,
  avalon_fp_master_if.master bus
);

  state_e      state_q, state_d;
  logic [63:0] a_q, b_q;
  logic        srst_q;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] cnt_q, cnt_d;
  logic        expired;
  logic        accepted;

  avm_stall_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_stall_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_d != state_q),
    .stall_i  ((bus.avm_write || bus.avm_read) && bus.avm_waitrequest),
    .expired_o(expired)
  );

  assign accepted = (bus.avm_write || bus.avm_read) && !bus.avm_waitrequest;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) begin
      a_q    <= bus.cmd_a;
      b_q    <= bus.cmd_b;
      srst_q <= bus.cmd_srst;
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid && bus.cmd_ready) state_d = bus.cmd_srst ? SRST : WR_A_LO;
      WR_A_LO: if (accepted) state_d = WR_A_HI;
      WR_A_HI: if (accepted) state_d = WR_B_LO;
      WR_B_LO: if (accepted) state_d = WR_B_HI;
      WR_B_HI: if (accepted) state_d = SETTLE;
      SETTLE:  if (cnt_q + 32'd1 >= 32'(SETTLE_CYCLES)) state_d = RD_REQ;
      RD_REQ:  if (accepted) state_d = RD_WAIT;
      RD_WAIT: begin
        // cnt_q restarts on entry, so this lands READ_LATENCY cycles after the read accept.
        if (cnt_q + 32'd1 >= 32'(READ_LATENCY)) begin
          rsp_data_d = bus.avm_readdata;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      SRST: begin
        if (accepted) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    // An expired transfer abandons every remaining write and the read.
    if (is_xfer(state_q) && expired) begin
      rsp_data_d = '0;
      rsp_err_d  = 1'b1;
      state_d    = RESP;
    end
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 32'd1;
  end

  always_comb begin
    bus.cmd_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_data       = rsp_data_q;
    bus.rsp_err        = rsp_err_q;
    bus.avm_write      = 1'b0;
    bus.avm_read       = 1'b0;
    bus.avm_address    = '0;
    bus.avm_writedata  = '0;
    bus.avm_byteenable = '0;
    bus.busy           = 1'b0;
    if (reset) begin
      bus.busy = (state_q != IDLE);
      case (state_q)
        IDLE:    bus.cmd_ready = 1'b1;
        WR_A_LO: begin
          bus.avm_write      = !expired;
          bus.avm_address    = ADDR_A;
          bus.avm_byteenable = BE_LO;
          bus.avm_writedata  = {32'h0, a_q[31:0]};
        end
        WR_A_HI: begin
          bus.avm_write      = !expired;
          bus.avm_address    = ADDR_A;
          bus.avm_byteenable = BE_HI;
          bus.avm_writedata  = {a_q[63:32], 32'h0};
        end
        WR_B_LO: begin
          bus.avm_write      = !expired;
          bus.avm_address    = ADDR_B;
          bus.avm_byteenable = BE_LO;
          bus.avm_writedata  = {32'h0, b_q[31:0]};
        end
        WR_B_HI: begin
          bus.avm_write      = !expired;
          bus.avm_address    = ADDR_B;
          bus.avm_byteenable = BE_HI;
          bus.avm_writedata  = {b_q[63:32], 32'h0};
        end
        RD_REQ: begin
          bus.avm_read       = !expired;
          bus.avm_address    = ADDR_A;
          bus.avm_byteenable = BE_ALL;
        end
        RESP:    bus.rsp_valid = 1'b1;
        SRST: begin
          bus.avm_write      = !expired;
          bus.avm_address    = ADDR_CTRL;
          bus.avm_byteenable = BE_ALL;
          bus.avm_writedata  = srst_q ? SRST_CMD : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/avalon_fp_master.md
AVALON_FP_MASTER -- requirements
Module: avalon_fp_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles any Avalon transfer may stall on waitrequest before abort.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, minimum cycles between final operand-write accept and read issue.
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles from read accept to readdata valid.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_a  in  64  operand A (IEEE-754 double).
REQ-009 cmd_b  in  64  operand B (IEEE-754 double).
REQ-010 cmd_srst  in  1  command is a soft reset of the slave, not an add.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-013 rsp_data  out  64  sum returned by slave.
REQ-014 rsp_err  out  1  transfer timed out; rsp_data is zero.
REQ-015 avm_address  out  3  Avalon-MM word address.
REQ-016 avm_writedata  out  64  write data.
REQ-017 avm_write / avm_read  out  1 each  transfer requests; never both high.
REQ-018 avm_byteenable  out  8  byte lanes.
REQ-019 avm_readdata  in  64  read data.
REQ-020 avm_waitrequest  in  1  slave stall.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 States SHALL be IDLE, WR_A_LO, WR_A_HI, WR_B_LO, WR_B_HI, SETTLE, RD_REQ, RD_WAIT, RESP, SRST.
REQ-023 cmd_ready SHALL be high only in IDLE; on accept cmd_a/cmd_b/cmd_srst SHALL be registered.
REQ-024 IDLE->SRST if cmd_srst, else IDLE->WR_A_LO.
REQ-025 WR_A_LO: address 0, byteenable 0x0F, writedata {32'h0, a[31:0]}; WR_A_HI: address 0, byteenable 0xF0, writedata {a[63:32], 32'h0}; WR_B_LO/WR_B_HI identical with address 1 and operand b.
REQ-026 A transfer SHALL be accepted on the cycle write or read is high and avm_waitrequest is low; signals SHALL hold stable until accepted; state advances the following cycle.
REQ-027 SETTLE SHALL count SETTLE_CYCLES cycles with write/read low, then go to RD_REQ.
REQ-028 RD_REQ: avm_read high, address 0, byteenable 0xFF until accepted, then RD_WAIT.
REQ-029 RD_WAIT SHALL capture avm_readdata exactly READ_LATENCY cycles after read accept into rsp_data, then RESP.
REQ-030 RESP: rsp_valid high, rsp_data/rsp_err stable until rsp_ready, then IDLE; cmd_ready low throughout.
REQ-031 SRST: one write, address 2, byteenable 0xFF, writedata 64'h1; on accept go to RESP with rsp_data 0, rsp_err 0.
REQ-032 A 32-bit stall counter SHALL clear on entry to each transfer state and increment each cycle waitrequest holds it off; reaching TIMEOUT_CYCLES SHALL drop write/read, set rsp_err=1, rsp_data=0, go to RESP.
REQ-033 A timeout on any add write SHALL skip remaining writes and the read.
REQ-034 Back-to-back: cmd accepted the cycle after rsp handshake (IDLE one cycle minimum).

Reset
REQ-035 While reset==0 at a clock edge: state IDLE, cmd_ready 0 on that cycle then 1, rsp_valid 0, rsp_err 0, rsp_data 0, avm_write 0, avm_read 0, avm_address 0, avm_writedata 0, avm_byteenable 0, busy 0, counters 0.
REQ-036 Reset mid-transfer SHALL abandon the transfer immediately with no further Avalon activity and no response.

Structure
REQ-037 A shared package SHALL hold the state enum, register addresses (ADDR_A=0, ADDR_B=1, ADDR_CTRL=2), byteenable constants (BE_LO=0x0F, BE_HI=0xF0, BE_ALL=0xFF) and SRST_CMD=64'h1.
REQ-038 One sub-module avm_stall_timer (stall counter plus timeout flag) SHALL be instantiated; everything else in one FSM.

Verification
REQ-039 Add: a=0x3FF0000000000000, b=0x4000000000000000, zero-wait slave -> four writes in order (0/0F, 0/F0, 1/0F, 1/F0), one read, rsp_data 0x4008000000000000, rsp_err 0.
REQ-040 Slave holds waitrequest 7 cycles on each write -> signals stable while stalled, same result, no extra transfers.
REQ-041 Slave never drops waitrequest, TIMEOUT_CYCLES=16 -> write dropped after 16 stall cycles, rsp_valid with rsp_err 1, rsp_data 0.
REQ-042 cmd_srst=1 -> single write address 2, data 1, BE 0xFF; rsp_valid with rsp_data 0.
REQ-043 rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, cmd_ready 0; then next command accepted after IDLE.
REQ-044 reset pulled low during WR_B_LO -> avm_write 0 next cycle, no response, next command runs normally.
